// File: rtl/ex_result_buffer.sv
// Execute-to-writeback result buffer: two-entry skid FIFO plus combinational forwarding lookup.
// Latency 1 cycle in->out; in_ready depends only on state/flush, so a stall never drops a result.
module ex_result_buffer #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic              out_zero,
  input  logic [RD_W-1:0]   lookup_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] main_result, skid_result;
  logic [RD_W-1:0]   main_rd, skid_rd;
  logic              main_wen, skid_wen, main_zero, skid_zero;

  logic in_fire, out_fire, cap_wen, cap_zero;
  logic load_main_in, load_main_skid, load_skid;
  logic main_hit, skid_hit;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign cap_wen  = in_wen && (in_rd != '0);
  assign cap_zero = (in_result == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state_nxt = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_nxt = FULL;
          else if (!in_fire && out_fire) state_nxt = EMPTY;
        end
        FULL:    if (out_fire) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Output / control logic
  always_comb begin
    in_ready       = (state != FULL) && !flush;
    out_valid      = (state != EMPTY);
    load_main_in   = in_fire && ((state == EMPTY) || ((state == ONE) && out_fire));
    load_skid      = in_fire && (state == ONE) && !out_fire;
    load_main_skid = out_fire && (state == FULL);
  end

  // Entry storage; main zero flag resets to 1 to stay consistent with a zero result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_result <= '0;
      main_rd     <= '0;
      main_wen    <= 1'b0;
      main_zero   <= 1'b1;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_wen    <= 1'b0;
      skid_zero   <= 1'b1;
    end else begin
      if (load_main_in) begin
        main_result <= in_result;
        main_rd     <= in_rd;
        main_wen    <= cap_wen;
        main_zero   <= cap_zero;
      end else if (load_main_skid) begin
        main_result <= skid_result;
        main_rd     <= skid_rd;
        main_wen    <= skid_wen;
        main_zero   <= skid_zero;
      end
      if (load_skid) begin
        skid_result <= in_result;
        skid_rd     <= in_rd;
        skid_wen    <= cap_wen;
        skid_zero   <= cap_zero;
      end
    end
  end

  assign out_result = main_result;
  assign out_rd     = main_rd;
  assign out_wen    = main_wen && out_valid;
  assign out_zero   = main_zero;

  // Youngest valid writable match wins; register 0 is never forwarded
  assign skid_hit = (state == FULL) && skid_wen && (skid_rd == lookup_rs) && (lookup_rs != '0);
  assign main_hit = (state != EMPTY) && main_wen && (main_rd == lookup_rs) && (lookup_rs != '0);
  assign fwd_hit  = skid_hit || main_hit;
  assign fwd_data = skid_hit ? skid_result : (main_hit ? main_result : '0);

endmodule

// File: tb/tb_ex_result_buffer.sv
// Directed bench for ex_result_buffer: reset, streaming, backpressure, forwarding, qualification, flush.
module tb_ex_result_buffer;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_wen, out_valid, out_ready;
  logic        out_wen, out_zero, fwd_hit;
  logic [31:0] in_result, out_result, fwd_data;
  logic [4:0]  in_rd, out_rd, lookup_rs;

  int total = 0;
  int bad   = 0;

  ex_result_buffer #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_wen(out_wen), .out_zero(out_zero),
    .lookup_rs(lookup_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd, input logic w);
    in_valid  = v;
    in_result = r;
    in_rd     = rd;
    in_wen    = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; lookup_rs = 5'd0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #12 rst_n = 1'b1;
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_wen", {31'd0, out_wen}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);

    // Streaming with out_ready held high
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0001, 5'd3, 1'b1);
    chk("str_in_ready0", {31'd0, in_ready}, 32'd1);
    tick();
    chk("str_valid0", {31'd0, out_valid}, 32'd1);
    chk("str_result0", out_result, 32'h0000_0001);
    chk("str_rd0", {27'd0, out_rd}, 32'd3);
    chk("str_wen0", {31'd0, out_wen}, 32'd1);
    chk("str_zero0", {31'd0, out_zero}, 32'd0);
    chk("str_in_ready1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h8000_0000, 5'd4, 1'b1);
    tick();
    chk("str_result1", out_result, 32'h8000_0000);
    chk("str_rd1", {27'd0, out_rd}, 32'd4);
    chk("str_in_ready2", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'hFFFF_FFFE, 5'd5, 1'b1);
    tick();
    chk("str_result2", out_result, 32'hFFFF_FFFE);
    chk("str_rd2", {27'd0, out_rd}, 32'd5);
    chk("str_in_ready3", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("str_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: two accepted, then stall
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 5'd7, 1'b1);
    tick();
    chk("bp_in_ready_a", {31'd0, in_ready}, 32'd1);
    chk("bp_out_a", out_result, 32'h10);
    drive(1'b1, 32'h20, 5'd8, 1'b1);
    tick();
    chk("bp_in_ready_b", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a1", out_result, 32'h10);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("bp_hold_a2", out_result, 32'h10);
    chk("bp_hold_rd", {27'd0, out_rd}, 32'd7);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    lookup_rs = 5'd8;
    #1 chk("bp_fwd8_data", fwd_data, 32'h20);
    lookup_rs = 5'd7;
    #1 chk("bp_fwd7_data", fwd_data, 32'h10);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", out_result, 32'h20);
    chk("bp_rd_b", {27'd0, out_rd}, 32'd8);
    chk("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Forwarding with both entries on rd 9
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd9, 1'b1);
    tick();
    drive(1'b1, 32'h22, 5'd9, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    lookup_rs = 5'd9;
    #1 chk("fwd_hit9", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_data9", fwd_data, 32'h22);
    lookup_rs = 5'd0;
    #1 chk("fwd_hit0", {31'd0, fwd_hit}, 32'd0);
    chk("fwd_data0", fwd_data, 32'd0);
    lookup_rs = 5'd10;
    #1 chk("fwd_miss10", {31'd0, fwd_hit}, 32'd0);

    // Flush while FULL with a capture attempt
    lookup_rs = 5'd9;
    flush = 1'b1;
    drive(1'b1, 32'h33, 5'd2, 1'b1);
    #1 chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    chk("fl_fwd_during", {31'd0, fwd_hit}, 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #1 chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_fwd_after", {31'd0, fwd_hit}, 32'd0);
    chk("fl_in_ready_after", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_33_never", {31'd0, out_valid}, 32'd0);

    // Flush and capture together on EMPTY
    flush = 1'b1;
    drive(1'b1, 32'h44, 5'd11, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    lookup_rs = 5'd11;
    #1 chk("fle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fle_fwd11", {31'd0, fwd_hit}, 32'd0);

    // Register-0 and wen qualification
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 5'd0, 1'b1);
    tick();
    lookup_rs = 5'd0;
    #1 chk("r0_valid", {31'd0, out_valid}, 32'd1);
    chk("r0_out_wen", {31'd0, out_wen}, 32'd0);
    chk("r0_fwd", {31'd0, fwd_hit}, 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'h66, 5'd6, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    lookup_rs = 5'd6;
    #1 chk("wen0_result", out_result, 32'h66);
    chk("wen0_out_wen", {31'd0, out_wen}, 32'd0);
    chk("wen0_fwd", {31'd0, fwd_hit}, 32'd0);
    tick();
    chk("wen0_drained", {31'd0, out_valid}, 32'd0);

    // Zero-result flag on a live entry
    out_ready = 1'b0;
    drive(1'b1, 32'h0, 5'd13, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("zero_flag", {31'd0, out_zero}, 32'd1);

    // Asynchronous reset mid-cycle with an entry held
    drive(1'b1, 32'h77, 5'd12, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    lookup_rs = 5'd12;
    #1 chk("ar_pre_hit", {31'd0, fwd_hit}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_out_zero", {31'd0, out_zero}, 32'd1);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    chk("ar_out_result", out_result, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_after_valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
